// File: rtl/video_pattern_gen.sv
// rtl/video_pattern_gen.sv - parametrised video timing and test-pattern generator
//
// Produces RGB, HS, VS and DE on the pixel clock for an HDMI encoder. Four
// run-time selectable patterns switch only on frame boundaries. All outputs are
// registered and lag the (hcnt,vcnt) position by one cycle.
//
// Ports:
//   i_clk          pixel clock
//   i_rst_n        asynchronous reset, active-low
//   i_pat_sel      0 colour bars, 1 grid, 2 gradient, 3 solid (latched per frame)
//   i_solid_rgb    {R,G,B} for the solid pattern, sampled live
//   o_vga_r/g/b    pixel colour, 0 outside the active area
//   o_vga_hs       horizontal sync, active level HS_POL
//   o_vga_vs       vertical sync, active level VS_POL
//   o_vga_de       data enable, high in the active area
//   o_frame_start  one-cycle pulse with the first DE pixel of each frame
//   o_frame_cnt    frame count, increments with o_frame_start, wraps 255->0
//
// Option macro PATTERN_SCROLL_EN: patterns 0-2 scroll by SCROLL_STEP pixels
// per frame. Without it no offset register is built.
module video_pattern_gen #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter bit          HS_POL   = 1'b0,
  parameter bit          VS_POL   = 1'b0,
  parameter int unsigned CW       = 8,
  parameter int unsigned GRID     = 32
`ifdef PATTERN_SCROLL_EN
  ,
  parameter int unsigned SCROLL_STEP = 1
`endif
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic [1:0]      i_pat_sel,
  input  logic [3*CW-1:0] i_solid_rgb,
  output logic [CW-1:0]   o_vga_r,
  output logic [CW-1:0]   o_vga_g,
  output logic [CW-1:0]   o_vga_b,
  output logic            o_vga_hs,
  output logic            o_vga_vs,
  output logic            o_vga_de,
  output logic            o_frame_start,
  output logic [7:0]      o_frame_cnt
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HW      = $clog2(H_TOTAL);
  localparam int unsigned VW      = $clog2(V_TOTAL);
  // Compares run one bit wider so a sync end equal to the total still fits.
  localparam int unsigned HX      = HW + 1;
  localparam int unsigned VX      = VW + 1;

  localparam logic [HX-1:0] H_LAST   = HX'(H_TOTAL - 1);
  localparam logic [HX-1:0] H_ACT    = HX'(H_ACTIVE);
  localparam logic [HX-1:0] HS_BEGIN = HX'(H_ACTIVE + H_FP);
  localparam logic [HX-1:0] HS_END   = HX'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VX-1:0] V_LAST   = VX'(V_TOTAL - 1);
  localparam logic [VX-1:0] V_ACT    = VX'(V_ACTIVE);
  localparam logic [VX-1:0] VS_BEGIN = VX'(V_ACTIVE + V_FP);
  localparam logic [VX-1:0] VS_END   = VX'(V_ACTIVE + V_FP + V_SYNC);

  localparam int unsigned   BAR_W   = H_ACTIVE / 8;
  localparam logic [HW-1:0] GX_MASK = HW'(GRID - 1);
  localparam logic [VW-1:0] GY_MASK = VW'(GRID - 1);

  logic [HW-1:0]   r_hcnt;
  logic [VW-1:0]   r_vcnt;
  logic [1:0]      r_pat_sel;
  logic [3*CW-1:0] r_rgb;
  logic            r_hs;
  logic            r_vs;
  logic            r_de;
  logic            r_frame_start;
  logic [7:0]      r_frame_cnt;

  logic [HX-1:0]   w_hcnt;
  logic [VX-1:0]   w_vcnt;
  logic            w_h_last;
  logic            w_frame_end;
  logic            w_frame_first;
  logic            w_active;
  logic            w_hs_on;
  logic            w_vs_on;

  always_comb begin
    w_hcnt        = {1'b0, r_hcnt};
    w_vcnt        = {1'b0, r_vcnt};
    w_h_last      = (w_hcnt == H_LAST);
    w_frame_end   = w_h_last && (w_vcnt == V_LAST);
    w_frame_first = (r_hcnt == '0) && (r_vcnt == '0);
    w_active      = (w_hcnt < H_ACT) && (w_vcnt < V_ACT);
    w_hs_on       = (w_hcnt >= HS_BEGIN) && (w_hcnt < HS_END);
    w_vs_on       = (w_vcnt >= VS_BEGIN) && (w_vcnt < VS_END);
  end

  // Position counters; the pattern select is captured on the last pixel so a
  // new selection always starts on a clean frame.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_hcnt    <= '0;
      r_vcnt    <= '0;
      r_pat_sel <= 2'd0;
    end else if (w_h_last) begin
      r_hcnt <= '0;
      if (w_frame_end) begin
        r_vcnt    <= '0;
        r_pat_sel <= i_pat_sel;
      end else begin
        r_vcnt <= r_vcnt + 1'b1;
      end
    end else begin
      r_hcnt <= r_hcnt + 1'b1;
    end
  end

  // Pattern x coordinate
  logic [HW-1:0] w_x;

`ifdef PATTERN_SCROLL_EN
  localparam logic [HX-1:0] STEP = HX'(SCROLL_STEP % H_ACTIVE);

  logic [HW-1:0] r_offset;
  logic [HX-1:0] w_xsum;
  logic [HX-1:0] w_osum;

  // Both operands are below H_ACTIVE, so one conditional subtract is a full mod.
  always_comb begin
    w_xsum = w_hcnt + {1'b0, r_offset};
    w_osum = {1'b0, r_offset} + STEP;
    w_x    = (w_xsum >= H_ACT) ? HW'(w_xsum - H_ACT) : HW'(w_xsum);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_offset <= '0;
    end else if (w_frame_end) begin
      r_offset <= (w_osum >= H_ACT) ? HW'(w_osum - H_ACT) : HW'(w_osum);
    end
  end
`else
  always_comb begin
    w_x = r_hcnt;
  end
`endif

  // Pattern generation
  logic [3:0]      w_bar;
  logic [2:0]      w_bar_rgb;
  logic            w_grid_on;
  logic [CW-1:0]   w_grad;
  logic [3*CW-1:0] w_rgb;

  always_comb begin
    // Thresholds ascend, so the last one passed gives the bar index; 8 means
    // the remainder columns past the last full bar.
    w_bar = 4'd0;
    for (int i = 1; i <= 8; i++) begin
      if ({1'b0, w_x} >= HX'(i * BAR_W)) begin
        w_bar = 4'(i);
      end
    end
    case (w_bar)
      4'd0:    w_bar_rgb = 3'b111;
      4'd1:    w_bar_rgb = 3'b110;
      4'd2:    w_bar_rgb = 3'b011;
      4'd3:    w_bar_rgb = 3'b010;
      4'd4:    w_bar_rgb = 3'b101;
      4'd5:    w_bar_rgb = 3'b100;
      4'd6:    w_bar_rgb = 3'b001;
      default: w_bar_rgb = 3'b000;
    endcase
    w_grid_on = ((w_x & GX_MASK) == '0) || ((r_vcnt & GY_MASK) == '0);
    w_grad    = CW'(w_x);
    case (r_pat_sel)
      2'd0:    w_rgb = {{CW{w_bar_rgb[2]}}, {CW{w_bar_rgb[1]}}, {CW{w_bar_rgb[0]}}};
      2'd1:    w_rgb = {(3*CW){w_grid_on}};
      2'd2:    w_rgb = {w_grad, w_grad, w_grad};
      default: w_rgb = i_solid_rgb;
    endcase
  end

  // Output registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rgb         <= '0;
      r_hs          <= ~HS_POL;
      r_vs          <= ~VS_POL;
      r_de          <= 1'b0;
      r_frame_start <= 1'b0;
      r_frame_cnt   <= 8'd0;
    end else begin
      r_rgb         <= w_active ? w_rgb : '0;
      r_hs          <= w_hs_on ? HS_POL : ~HS_POL;
      r_vs          <= w_vs_on ? VS_POL : ~VS_POL;
      r_de          <= w_active;
      r_frame_start <= w_frame_first;
      if (w_frame_first) begin
        r_frame_cnt <= r_frame_cnt + 8'd1;
      end
    end
  end

  assign o_vga_r       = r_rgb[3*CW-1:2*CW];
  assign o_vga_g       = r_rgb[2*CW-1:CW];
  assign o_vga_b       = r_rgb[CW-1:0];
  assign o_vga_hs      = r_hs;
  assign o_vga_vs      = r_vs;
  assign o_vga_de      = r_de;
  assign o_frame_start = r_frame_start;
  assign o_frame_cnt   = r_frame_cnt;

endmodule

// File: tb/tb_video_pattern_gen.sv
// tb/tb_video_pattern_gen.sv - directed self-checking bench for video_pattern_gen
module tb_video_pattern_gen;

  // Reduced timing: 68 active pixels (8 bars of 8 plus 4 remainder columns)
  localparam int HA = 68, HF = 4, HSW = 8, HB = 4;
  localparam int VA = 40, VF = 2, VSW = 2, VB = 4;
  localparam int HT = 84;
  localparam int VT = 48;
  localparam int FT = HT * VT;
`ifdef PATTERN_SCROLL_EN
  localparam int STEP = 1;
`else
  localparam int STEP = 0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  pat_sel = 2'd0;
  logic [23:0] solid = 24'h0;
  logic [7:0]  r, g, b;
  logic        hs, vs, de, fs;
  logic [7:0]  fcnt;

  int checks = 0;
  int errors = 0;
  int pos = -1;   // index within the run of the pixel currently on the outputs

  always #5 clk = ~clk;

  video_pattern_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSW), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSW), .V_BP(VB),
    .HS_POL(1'b0), .VS_POL(1'b1), .CW(8), .GRID(8)
  ) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_pat_sel    (pat_sel),
    .i_solid_rgb  (solid),
    .o_vga_r      (r),
    .o_vga_g      (g),
    .o_vga_b      (b),
    .o_vga_hs     (hs),
    .o_vga_vs     (vs),
    .o_vga_de     (de),
    .o_frame_start(fs),
    .o_frame_cnt  (fcnt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
    pos++;
  endtask

  task automatic goto(input int h, input int v);
    int n = 0;
    while (!(pos >= 0 && pos % HT == h && (pos / HT) % VT == v) && n < FT + 2) begin
      tick();
      n++;
    end
    if (n >= FT + 2) begin
      checks++;
      errors++;
      $display("FAIL goto(%0d,%0d): position not reached within %0d cycles", h, v, FT + 2);
    end
  endtask

  function automatic int exp_x(input int h);
    return (h + (pos / FT) * STEP) % HA;
  endfunction

  function automatic logic [23:0] bar_rgb(input int x);
    case (x / 8)
      0:       return 24'hFFFFFF;
      1:       return 24'hFFFF00;
      2:       return 24'h00FFFF;
      3:       return 24'h00FF00;
      4:       return 24'hFF00FF;
      5:       return 24'hFF0000;
      6:       return 24'h0000FF;
      default: return 24'h000000;
    endcase
  endfunction

  task automatic test_reset();
    logic [35:0] rst_vec = {24'h0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00};
    logic [35:0] first_vec = {24'hFFFFFF, 1'b1, 1'b1, 1'b0, 1'b1, 8'h01};
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({r, g, b, de, hs, vs, fs, fcnt} !== rst_vec) begin
      errors++;
      $display("FAIL reset_held: got %h expected %h", {r, g, b, de, hs, vs, fs, fcnt}, rst_vec);
    end
    rst_n = 1'b1;
    pos = -1;
    #2;
    checks++;
    if ({r, g, b, de, hs, vs, fs, fcnt} !== rst_vec) begin
      errors++;
      $display("FAIL reset_released_no_edge: got %h expected %h", {r, g, b, de, hs, vs, fs, fcnt}, rst_vec);
    end
    tick();
    checks++;
    if ({r, g, b, de, hs, vs, fs, fcnt} !== first_vec) begin
      errors++;
      $display("FAIL first_pixel: got %h expected %h", {r, g, b, de, hs, vs, fs, fcnt}, first_vec);
    end
    tick();
    checks++;
    if ({fs, de, fcnt} !== {1'b0, 1'b1, 8'h01}) begin
      errors++;
      $display("FAIL second_pixel fs/de/cnt: got %b/%b/%0d expected 0/1/1", fs, de, fcnt);
    end
  endtask

  task automatic test_bars();
    int          xs [12] = '{0, 7, 8, 16, 24, 32, 40, 48, 56, 63, 64, 70};
    logic [23:0] es [12] = '{24'hFFFFFF, 24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00, 24'hFF00FF,
                             24'hFF0000, 24'h0000FF, 24'h000000, 24'h000000, 24'h000000, 24'h000000};
    for (int i = 0; i < 12; i++) begin
      goto(xs[i], 5);
      checks++;
      if ({r, g, b} !== es[i]) begin
        errors++;
        $display("FAIL bars x=%0d: got %h expected %h", xs[i], {r, g, b}, es[i]);
      end
    end
  endtask

  task automatic test_line_timing();
    int de_cnt = 0, hs_cnt = 0, hs_first = -1, p_fall = 0, n = 0;
    goto(0, 10);
    for (int i = 0; i < HT; i++) begin
      if (de === 1'b1) de_cnt++;
      if (hs === 1'b0) begin
        hs_cnt++;
        if (hs_first < 0) begin
          hs_first = i;
          p_fall = pos;
        end
      end
      tick();
    end
    while (hs !== 1'b0 && n < 2 * HT) begin
      tick();
      n++;
    end
    checks++;
    if (de_cnt != 68) begin
      errors++;
      $display("FAIL line_de_width: got %0d expected 68", de_cnt);
    end
    checks++;
    if (hs_cnt != 8) begin
      errors++;
      $display("FAIL line_hs_width: got %0d expected 8", hs_cnt);
    end
    checks++;
    if (hs_first != 72) begin
      errors++;
      $display("FAIL line_hs_start: got %0d expected 72", hs_first);
    end
    checks++;
    if (pos - p_fall != 84) begin
      errors++;
      $display("FAIL line_hs_period: got %0d expected 84", pos - p_fall);
    end
  endtask

  task automatic test_pat_switch();
    int          hs_t [8] = '{0, 5, 8, 64, 5, 9, 3, 67};
    int          vs_t [8] = '{0, 3, 3, 5, 8, 9, 32, 39};
    logic [23:0] exp;
    goto(0, 20);
    pat_sel = 2'd1;
    goto(12, 25);
    checks++;
    if ({r, g, b} !== 24'hFFFF00) begin
      errors++;
      $display("FAIL switch_same_frame x=12: got %h expected ffff00", {r, g, b});
    end
    goto(16, 25);
    checks++;
    if ({r, g, b} !== 24'h00FFFF) begin
      errors++;
      $display("FAIL switch_same_frame x=16: got %h expected 00ffff", {r, g, b});
    end
    for (int i = 0; i < 8; i++) begin
      goto(hs_t[i], vs_t[i]);
      exp = ((exp_x(hs_t[i]) % 8 == 0) || (vs_t[i] % 8 == 0)) ? 24'hFFFFFF : 24'h000000;
      checks++;
      if ({r, g, b} !== exp) begin
        errors++;
        $display("FAIL grid (%0d,%0d): got %h expected %h", hs_t[i], vs_t[i], {r, g, b}, exp);
      end
    end
    pat_sel = 2'd2;
  endtask

  task automatic test_frame_timing();
    int lines = 0, vs_cnt = 0, vs_first = -1, fs_cnt = 0, hs_cnt = 0;
    logic prev_de = 1'b0;
    goto(0, 0);
    checks++;
    if ({fs, fcnt} !== {1'b1, 8'd3}) begin
      errors++;
      $display("FAIL frame2_start fs/cnt: got %b/%0d expected 1/3", fs, fcnt);
    end
    for (int i = 0; i < FT; i++) begin
      if (de === 1'b1 && prev_de === 1'b0) lines++;
      prev_de = de;
      if (vs === 1'b1) begin
        vs_cnt++;
        if (vs_first < 0) vs_first = i;
      end
      if (hs === 1'b0) hs_cnt++;
      if (fs === 1'b1) fs_cnt++;
      tick();
    end
    checks++;
    if (lines != 40) begin
      errors++;
      $display("FAIL frame_de_lines: got %0d expected 40", lines);
    end
    checks++;
    if (vs_cnt != 168 || vs_first != 3528) begin
      errors++;
      $display("FAIL frame_vs width/start: got %0d/%0d expected 168/3528", vs_cnt, vs_first);
    end
    checks++;
    if (hs_cnt != 384) begin
      errors++;
      $display("FAIL frame_hs_total: got %0d expected 384", hs_cnt);
    end
    checks++;
    if (fs_cnt != 1) begin
      errors++;
      $display("FAIL frame_start_count: got %0d expected 1", fs_cnt);
    end
    checks++;
    if ({fs, fcnt} !== {1'b1, 8'd4}) begin
      errors++;
      $display("FAIL frame_start_period fs/cnt: got %b/%0d expected 1/4", fs, fcnt);
    end
  endtask

  task automatic test_gradient();
    int          hs_t [5] = '{0, 37, 67, 70, 5};
    int          vs_t [5] = '{1, 1, 1, 1, 45};
    logic [23:0] exp;
    logic [7:0]  xv;
    for (int i = 0; i < 5; i++) begin
      goto(hs_t[i], vs_t[i]);
      xv = 8'(exp_x(hs_t[i]));
      exp = (hs_t[i] < HA && vs_t[i] < VA) ? {xv, xv, xv} : 24'h000000;
      checks++;
      if ({r, g, b} !== exp) begin
        errors++;
        $display("FAIL gradient (%0d,%0d): got %h expected %h", hs_t[i], vs_t[i], {r, g, b}, exp);
      end
    end
    pat_sel = 2'd3;
    solid = 24'h123456;
  endtask

  task automatic test_solid();
    goto(0, 0);
    checks++;
    if ({r, g, b, fcnt} !== {24'h123456, 8'd5}) begin
      errors++;
      $display("FAIL solid_first rgb/cnt: got %h/%0d expected 123456/5", {r, g, b}, fcnt);
    end
    goto(30, 20);
    checks++;
    if ({r, g, b} !== 24'h123456) begin
      errors++;
      $display("FAIL solid (30,20): got %h expected 123456", {r, g, b});
    end
    solid = 24'hABCDEF;
    tick();
    checks++;
    if ({r, g, b} !== 24'hABCDEF) begin
      errors++;
      $display("FAIL solid_live (31,20): got %h expected abcdef", {r, g, b});
    end
    goto(67, 39);
    checks++;
    if ({r, g, b} !== 24'hABCDEF) begin
      errors++;
      $display("FAIL solid (67,39): got %h expected abcdef", {r, g, b});
    end
    goto(68, 39);
    checks++;
    if ({r, g, b, de} !== {24'h0, 1'b0}) begin
      errors++;
      $display("FAIL solid_blank (68,39) rgb/de: got %h/%b expected 000000/0", {r, g, b}, de);
    end
    pat_sel = 2'd0;
  endtask

  task automatic test_reset_midframe();
    logic [35:0] rst_vec = {24'h0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00};
    logic [35:0] first_vec = {24'hFFFFFF, 1'b1, 1'b1, 1'b0, 1'b1, 8'h01};
    goto(10, 30);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({r, g, b, de, hs, vs, fs, fcnt} !== rst_vec) begin
      errors++;
      $display("FAIL midframe_reset_async: got %h expected %h", {r, g, b, de, hs, vs, fs, fcnt}, rst_vec);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    pos = -1;
    tick();
    checks++;
    if ({r, g, b, de, hs, vs, fs, fcnt} !== first_vec) begin
      errors++;
      $display("FAIL midframe_restart: got %h expected %h", {r, g, b, de, hs, vs, fs, fcnt}, first_vec);
    end
    goto(71, 0);
    checks++;
    if (hs !== 1'b1) begin
      errors++;
      $display("FAIL restart_hs x=71: got %b expected 1", hs);
    end
    tick();
    checks++;
    if (hs !== 1'b0) begin
      errors++;
      $display("FAIL restart_hs x=72: got %b expected 0", hs);
    end
  endtask

  task automatic test_scroll();
    int          hs_t [5] = '{0, 6, 62, 66, 67};
    logic [23:0] exp;
    repeat (2 * FT - pos) tick();
    checks++;
    if ({fs, fcnt} !== {1'b1, 8'd3}) begin
      errors++;
      $display("FAIL scroll_frame2 fs/cnt: got %b/%0d expected 1/3", fs, fcnt);
    end
    for (int i = 0; i < 5; i++) begin
      goto(hs_t[i], 0);
      exp = bar_rgb(exp_x(hs_t[i]));
      checks++;
      if ({r, g, b} !== exp) begin
        errors++;
        $display("FAIL scroll_bars frame2 x=%0d: got %h expected %h", hs_t[i], {r, g, b}, exp);
      end
    end
  endtask

  initial begin
    test_reset();
    test_bars();
    test_line_timing();
    test_pat_switch();
    test_frame_timing();
    test_gradient();
    test_solid();
    test_reset_midframe();
    test_scroll();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached at pixel %0d", pos);
    $fatal(1, "time limit");
  end

endmodule
